fetch_pc_gen: RTL

Parametrised fetch program-counter generator for the front end, replacing the fixed four-halfword PC unit. It holds the fetch PC and issues one fetch-block request per handshake. It consumes branch-predictor results for the requested block and captures the returned instruction halfwords. It then presents a per-slot annotated block (PC, valid, branch ID, prediction) to decode through a valid/ready handshake with full back-pressure and redirect flush.

---
 rtl/fetch_pc_gen.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues one block request per handshake and annotates the returned block with predictor info.
// Optional mapping-window check is enabled by defining FETCH_MAP_CHECK_EN.
module fetch_pc_gen #(
  parameter int          BLOCK_HW = 4,
  parameter int          BID_W    = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      IN_redirect,
  input  logic [31:0]               IN_redirectPC,
  output logic [31:0]               OUT_fetchPC,
  output logic                      OUT_fetchValid,
  input  logic                      IN_fetchReady,
  input  logic [16*BLOCK_HW-1:0]    IN_instr,
  input  logic                      IN_BP_branchFound,
  input  logic                      IN_BP_branchTaken,
  input  logic                      IN_BP_isJump,
  input  logic                      IN_BP_multipleBranches,
  input  logic [31:0]               IN_BP_branchSrc,
  input  logic [31:0]               IN_BP_branchDst,
  input  logic [BID_W-1:0]          IN_BP_branchID,
  input  logic [31:0]               IN_mapBase,
  input  logic [31:0]               IN_mapSize,
  output logic                      OUT_blockValid,
  input  logic                      IN_blockReady,
  output logic [BLOCK_HW-1:0]       OUT_slotValid,
  output logic [31:0]               OUT_blockPC,
  output logic [16*BLOCK_HW-1:0]    OUT_slotInstr,
  output logic [BID_W*BLOCK_HW-1:0] OUT_slotBranchID,
  output logic [BLOCK_HW-1:0]       OUT_slotBranchPred,
  output logic                      OUT_blockMiss
);
  localparam int OW = $clog2(BLOCK_HW);

  logic [30:0] pc_q, pc_d;
  logic        halted_q;

  logic                           m_valid_q, m_held_q, m_miss_q;
  logic [30:0]                    m_pc_q;
  logic [BLOCK_HW-1:0]            m_mask_q, m_pred_q;
  logic [BLOCK_HW-1:0][BID_W-1:0] m_bid_q;
  logic [BLOCK_HW-1:0][15:0]      m_instr_q, m_instr_cur;

  logic                           o_valid_q, o_miss_q;
  logic [30:0]                    o_pc_q;
  logic [BLOCK_HW-1:0]            o_mask_q, o_pred_q;
  logic [BLOCK_HW-1:0][BID_W-1:0] o_bid_q;
  logic [BLOCK_HW-1:0][15:0]      o_instr_q;

  logic                           fh, m_xfer, accept, fh_miss;
  logic [OW-1:0]                  off, src_slot;
  logic [30:0]                    base_pc, next_base, fh_next_pc;
  logic [BLOCK_HW-1:0]            from_off, upto_src, fh_mask, fh_pred;
  logic [BLOCK_HW-1:0][BID_W-1:0] fh_bid;

  assign off       = pc_q[OW-1:0];
  assign src_slot  = IN_BP_branchSrc[OW:1];
  assign base_pc   = {pc_q[30:OW], {OW{1'b0}}};
  assign next_base = base_pc + 31'(BLOCK_HW);

  generate
    for (genvar gi = 0; gi < BLOCK_HW; gi++) begin : g_slot
      assign from_off[gi] = OW'(gi) >= off;
      assign upto_src[gi] = OW'(gi) <= src_slot;
    end
  endgenerate

  // Block contents and next PC for a request handshaken this cycle.
  always_comb begin
    fh_next_pc = next_base;
    fh_mask    = from_off;
    fh_bid     = '1;
    fh_pred    = '0;
    if (IN_BP_branchFound) begin
      fh_bid[src_slot] = IN_BP_branchID;
      if (IN_BP_isJump | IN_BP_branchTaken) begin
        fh_next_pc        = IN_BP_branchDst[31:1];
        fh_mask           = from_off & upto_src;
        fh_pred[src_slot] = 1'b1;
      end else if (IN_BP_multipleBranches) begin
        fh_next_pc = IN_BP_branchSrc[31:1] + 31'd1;
        fh_mask    = from_off & upto_src;
      end
    end
  end

`ifdef FETCH_MAP_CHECK_EN
  logic [32:0] fetch_addr, map_lo, map_hi;
  assign fetch_addr = {1'b0, pc_q, 1'b0};
  assign map_lo     = {1'b0, IN_mapBase};
  assign map_hi     = map_lo + {1'b0, IN_mapSize};
  assign fh_miss    = (fetch_addr < map_lo) | (fetch_addr >= map_hi);
`else
  logic unused_map;
  assign unused_map = ^{IN_mapBase, IN_mapSize};
  assign fh_miss    = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{IN_redirectPC[0], IN_BP_branchSrc[0], IN_BP_branchDst[0]};

  // M always has its instructions by the cycle after it loads, so it can move whenever O has room.
  assign m_xfer         = m_valid_q & (!o_valid_q | IN_blockReady);
  assign accept         = o_valid_q & IN_blockReady;
  assign OUT_fetchValid = !rst & !IN_redirect & !halted_q & (!m_valid_q | m_xfer);
  assign fh             = OUT_fetchValid & IN_fetchReady;
  assign m_instr_cur    = m_held_q ? m_instr_q : IN_instr;

  always_comb begin
    pc_d = pc_q;
    if (IN_redirect) pc_d = IN_redirectPC[31:1];
    else if (fh)     pc_d = fh_next_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC[31:1];
      halted_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_held_q  <= 1'b0;
      m_miss_q  <= 1'b0;
      o_valid_q <= 1'b0;
      o_miss_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (IN_redirect) begin
        halted_q <= 1'b0;
`ifdef FETCH_MAP_CHECK_EN
      end else if (fh && fh_miss) begin
        halted_q <= 1'b1;
`endif
      end

      if (IN_redirect) begin
        m_valid_q <= 1'b0;
        m_held_q  <= 1'b0;
      end else if (fh) begin
        m_valid_q <= 1'b1;
        m_held_q  <= 1'b0;
        m_miss_q  <= fh_miss;
      end else begin
        if (m_xfer) m_valid_q <= 1'b0;
        if (m_valid_q && !m_held_q) m_held_q <= 1'b1;
      end

      if (IN_redirect) begin
        o_valid_q <= 1'b0;
        o_miss_q  <= 1'b0;
      end else if (m_xfer) begin
        o_valid_q <= 1'b1;
        o_miss_q  <= m_miss_q;
      end else if (accept) begin
        o_valid_q <= 1'b0;
        o_miss_q  <= 1'b0;
      end
    end
  end

  // Payload registers carry no reset; their valids qualify them.
  always_ff @(posedge clk) begin
    if (fh) begin
      m_pc_q   <= base_pc;
      m_mask_q <= fh_miss ? '0 : fh_mask;
      m_bid_q  <= fh_bid;
      m_pred_q <= fh_pred;
    end
    if (m_valid_q && !m_held_q) m_instr_q <= IN_instr;
    if (m_xfer) begin
      o_pc_q    <= m_pc_q;
      o_mask_q  <= m_mask_q;
      o_bid_q   <= m_bid_q;
      o_pred_q  <= m_pred_q;
      o_instr_q <= m_instr_cur;
    end
  end

  assign OUT_fetchPC        = {pc_q, 1'b0};
  assign OUT_blockValid     = o_valid_q;
  assign OUT_slotValid      = o_mask_q;
  assign OUT_blockPC        = {o_pc_q, 1'b0};
  assign OUT_slotInstr      = o_instr_q;
  assign OUT_slotBranchID   = o_bid_q;
  assign OUT_slotBranchPred = o_pred_q;
  assign OUT_blockMiss      = o_miss_q;
endmodule
